// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_master
// Brief    : Load/store unit driving a single-port data memory (combinational
//            read, clocked write). One request at a time over valid/ready,
//            byte-lane store steering, load extraction with sign/zero
//            extension and a registered response held until accepted.
//            Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word
//            accesses into error responses instead of truncating the offset.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_master #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [3:0]  mem_byte_enable
);

    localparam logic [31:0] c_MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;

    logic        w_f3_legal;
    logic        w_out_of_range;
    logic        w_misalign;
    logic        w_req_err;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    // Request qualification: legal width codes and address range
    always_comb begin
        w_f3_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_legal = 1'b1;
            default:                                w_f3_legal = 1'b0;
        endcase
    end

    assign w_out_of_range = (req_addr >= c_MEM_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    // Misaligned low bits are simply dropped by the lane logic below
    assign w_misalign = 1'b0;
`endif

    assign w_req_err = !w_f3_legal || w_out_of_range || w_misalign;

    // Store lane steering: byte enables from the offset, data replicated
    always_comb begin
        w_st_be   = 4'b1111;
        w_st_data = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_st_be   = 4'b0001 << req_addr[1:0];
                w_st_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_st_be   = req_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{req_wdata[15:0]}};
            end
            default: begin
                w_st_be   = 4'b1111;
                w_st_data = req_wdata;
            end
        endcase
    end

    assign w_ld_byte = 8'(mem_rdata >> {r_off, 3'b000});
    assign w_ld_half = 16'(mem_rdata >> {r_off[1], 4'b0000});

    // Load extraction and sign/zero extension from the latched request
    always_comb begin
        w_ld_data = mem_rdata;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_data = {24'd0, w_ld_byte};
            3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = mem_rdata;
        endcase
    end

    // Control FSM with registered memory strobes and response
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_we            <= 1'b0;
            r_funct3        <= 3'd0;
            r_off           <= 2'd0;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= 32'd0;
            resp_error      <= 1'b0;
            mem_address     <= 32'd0;
            mem_wdata       <= 32'd0;
            mem_we          <= 1'b0;
            mem_byte_enable <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_we      <= req_we;
                        r_funct3  <= req_funct3;
                        r_off     <= req_addr[1:0];
                        req_ready <= 1'b0;
                        if (w_req_err) begin
                            // Rejected request: answer immediately, no memory cycle
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            r_state         <= S_ACCESS;
                            mem_address     <= req_addr;
                            mem_wdata       <= w_st_data;
                            mem_we          <= req_we;
                            mem_byte_enable <= req_we ? w_st_be : 4'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    // The write (if any) lands at this edge; loads sample here
                    mem_we          <= 1'b0;
                    mem_byte_enable <= 4'd0;
                    r_state         <= S_RESP;
                    resp_valid      <= 1'b1;
                    resp_error      <= 1'b0;
                    resp_rdata      <= r_we ? 32'd0 : w_ld_data;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    req_ready       <= 1'b1;
                    resp_valid      <= 1'b0;
                    mem_we          <= 1'b0;
                    mem_byte_enable <= 4'd0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
